// File: rtl/fan_adder_node.sv
// FAN reduction node: merges one left-half and one right-half partial sum with matching rows.
// Optional build macro FAN_ADD_SAT_EN selects signed saturating sub-word adds instead of wrapping.
module fan_adder_node #(
    parameter int NUM_IN      = 6,
    parameter int N_STACK     = 4,
    parameter int DW_DATA     = 32,
    parameter int DW_ROW      = 4,
    parameter int DW_CTRL     = 4,
    parameter int DW_LINE     = N_STACK*DW_DATA+DW_ROW+DW_CTRL,
    parameter int PIPE_STAGES = 1,
    parameter int CNT_W       = 16,
    parameter int SYMMETRY    = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_IN*DW_LINE-1:0] in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_IN*DW_LINE-1:0] out,
    output logic [CNT_W-1:0]          merge_cnt,
    output logic                      err_multi
);
    localparam int          DW_D  = N_STACK * DW_DATA;
    localparam int          BW    = NUM_IN * DW_LINE;
    localparam int unsigned HALF  = NUM_IN / 2;
    localparam int unsigned OUT_L = HALF - 1;
    localparam int unsigned OUT_R = HALF;

    function automatic logic [DW_D-1:0] add_lanes(input logic [DW_D-1:0] a,
                                                  input logic [DW_D-1:0] b);
`ifdef FAN_ADD_SAT_EN
        logic [DW_DATA:0] s;
`endif
        add_lanes = '0;
        for (int unsigned k = 0; k < N_STACK; k++) begin
`ifdef FAN_ADD_SAT_EN
            // one guard bit: overflow when it disagrees with the sign bit
            s = {a[k*DW_DATA+DW_DATA-1], a[k*DW_DATA +: DW_DATA]}
              + {b[k*DW_DATA+DW_DATA-1], b[k*DW_DATA +: DW_DATA]};
            if (s[DW_DATA] != s[DW_DATA-1])
                add_lanes[k*DW_DATA +: DW_DATA] = s[DW_DATA] ? {1'b1, {(DW_DATA-1){1'b0}}}
                                                             : {1'b0, {(DW_DATA-1){1'b1}}};
            else
                add_lanes[k*DW_DATA +: DW_DATA] = s[DW_DATA-1:0];
`else
            add_lanes[k*DW_DATA +: DW_DATA] = a[k*DW_DATA +: DW_DATA] + b[k*DW_DATA +: DW_DATA];
`endif
        end
    endfunction

    function automatic logic [BW-1:0] place(input logic [BW-1:0]     bundle,
                                            input logic              merge,
                                            input logic              posr,
                                            input logic [3:0]        ctrl,
                                            input logic [DW_ROW-1:0] row,
                                            input logic [NUM_IN-1:0] cand,
                                            input logic [DW_D-1:0]   sum);
        place = bundle;
        if (merge) begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (i == OUT_L || i == OUT_R)
                    place[i*DW_LINE +: DW_LINE] = ((i == OUT_R) == posr) ? {ctrl, row, sum} : '0;
                else if (cand[i] || !bundle[i*DW_LINE + DW_D + DW_ROW + 2])
                    place[i*DW_LINE +: DW_LINE] = '0;
            end
        end
    endfunction

    logic [NUM_IN-1:0]  d_cand;
    logic               d_merge, d_multi, d_posr;
    logic [3:0]         d_ctrl;
    logic [DW_ROW-1:0]  d_row, r_row;
    logic [DW_D-1:0]    d_opa, d_opb;
    logic [1:0]         d_lb, d_rb;
    logic [DW_CTRL-1:0] lane_ctrl;
    int unsigned        n_l, n_r;
    logic               accept;

    always_comb begin
        d_cand    = '0;
        n_l       = 0;
        n_r       = 0;
        d_opa     = '0;
        d_opb     = '0;
        d_row     = '0;
        r_row     = '0;
        d_lb      = '0;
        d_rb      = '0;
        lane_ctrl = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            lane_ctrl = in[i*DW_LINE + DW_D + DW_ROW +: DW_CTRL];
            d_cand[i] = lane_ctrl[3] & ~lane_ctrl[2];
            if (d_cand[i]) begin
                if (i < HALF) begin
                    n_l   = n_l + 1;
                    d_opa = in[i*DW_LINE +: DW_D];
                    d_row = in[i*DW_LINE + DW_D +: DW_ROW];
                    d_lb  = lane_ctrl[1:0];
                end else begin
                    n_r   = n_r + 1;
                    d_opb = in[i*DW_LINE +: DW_D];
                    r_row = in[i*DW_LINE + DW_D +: DW_ROW];
                    d_rb  = lane_ctrl[1:0];
                end
            end
        end
        d_multi = (n_l > 1) || (n_r > 1);
        d_merge = (n_l == 1) && (n_r == 1) && (d_row == r_row);
        if (d_lb == 2'b01 && d_rb == 2'b10) begin
            d_ctrl = 4'b0111;
            d_posr = 1'b0;
        end else if (d_lb == 2'b01) begin
            d_ctrl = 4'b1001;
            d_posr = 1'b1;
        end else if (d_rb == 2'b10) begin
            d_ctrl = 4'b1010;
            d_posr = 1'b0;
        end else begin
            d_ctrl = 4'b1000;
            d_posr = (SYMMETRY == 1);
        end
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            merge_cnt <= '0;
            err_multi <= 1'b0;
        end else if (accept) begin
            if (d_merge && merge_cnt != '1)
                merge_cnt <= merge_cnt + 1'b1;
            if (d_multi)
                err_multi <= 1'b1;
        end
    end

    generate
        if (PIPE_STAGES == 2) begin : g_pipe2
            logic              s1_valid, s2_valid, s1_merge, s1_posr, s2_en;
            logic [3:0]        s1_ctrl;
            logic [DW_ROW-1:0] s1_row;
            logic [NUM_IN-1:0] s1_cand;
            logic [DW_D-1:0]   s1_opa, s1_opb;
            logic [BW-1:0]     s1_bundle, s2_out;

            assign s2_en     = !s2_valid || out_ready;
            assign in_ready  = !s1_valid || s2_en;
            assign out_valid = s2_valid;
            assign out       = s2_out;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid  <= 1'b0;
                    s2_valid  <= 1'b0;
                    s1_merge  <= 1'b0;
                    s1_posr   <= 1'b0;
                    s1_ctrl   <= '0;
                    s1_row    <= '0;
                    s1_cand   <= '0;
                    s1_opa    <= '0;
                    s1_opb    <= '0;
                    s1_bundle <= '0;
                    s2_out    <= '0;
                end else begin
                    if (in_ready) begin
                        s1_valid <= in_valid;
                        if (in_valid) begin
                            s1_merge  <= d_merge;
                            s1_posr   <= d_posr;
                            s1_ctrl   <= d_ctrl;
                            s1_row    <= d_row;
                            s1_cand   <= d_cand;
                            s1_opa    <= d_opa;
                            s1_opb    <= d_opb;
                            s1_bundle <= in;
                        end
                    end
                    if (s2_en) begin
                        s2_valid <= s1_valid;
                        if (s1_valid)
                            s2_out <= place(s1_bundle, s1_merge, s1_posr, s1_ctrl, s1_row,
                                            s1_cand, add_lanes(s1_opa, s1_opb));
                    end
                end
            end
        end else begin : g_pipe1
            logic          s_valid;
            logic [BW-1:0] s_out;

            assign in_ready  = !s_valid || out_ready;
            assign out_valid = s_valid;
            assign out       = s_out;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_valid <= 1'b0;
                    s_out   <= '0;
                end else if (in_ready) begin
                    s_valid <= in_valid;
                    if (in_valid)
                        s_out <= place(in, d_merge, d_posr, d_ctrl, d_row, d_cand,
                                       add_lanes(d_opa, d_opb));
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_fan_adder_node.sv
// Bench for fan_adder_node: one-stage and two-stage instances against a lane-level reference model.
module tb_fan_adder_node;
    localparam int NI  = 6;
    localparam int NS  = 4;
    localparam int LW  = NS*32 + 4 + 4;
    localparam int BW  = NI * LW;
    localparam int RLO = NS*32;
    localparam int SYM = 0;
`ifdef FAN_ADD_SAT_EN
    localparam logic [31:0] SAT_EXP = 32'h7FFFFFFF;
`else
    localparam logic [31:0] SAT_EXP = 32'h80000010;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          iv[2], ir[2], ov[2], ordy[2], emul[2];
    logic [BW-1:0] din[2], dout[2];
    logic [15:0]   mcnt[2];

    logic [BW-1:0] sb_b[2][512];
    int            sb_t[2][512];
    int            hd[2], tl[2], exp_cnt[2], delivered[2];
    bit            exp_err[2], acc_last[2], blocked[2];
    int            cyc = 0;
    int            n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    fan_adder_node #(.PIPE_STAGES(1), .SYMMETRY(SYM)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in(din[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out(dout[0]), .merge_cnt(mcnt[0]),
        .err_multi(emul[0]));

    fan_adder_node #(.PIPE_STAGES(2), .SYMMETRY(SYM)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in(din[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out(dout[1]), .merge_cnt(mcnt[1]),
        .err_multi(emul[1]));

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] mk(input logic [3:0] c, input logic [3:0] r, input logic [31:0] w);
        return {c, r, {NS{w}}};
    endfunction

    // Reference: find candidates per half, then build the output lane by lane.
    function automatic void model(input logic [BW-1:0] b, output logic [BW-1:0] res,
                                  output bit mg, output bit mu);
        logic [LW-1:0] ln[NI];
        int            lc[$], rc[$];
        logic [3:0]    c, cc, row;
        logic [1:0]    lb, rb;
        logic [RLO-1:0] sum;
        longint        a;
        int            pos, L, R;
        for (int i = 0; i < NI; i++) begin
            ln[i] = b[i*LW +: LW];
            c = ln[i][LW-1 -: 4];
            if (c[3] && !c[2]) begin
                if (i < NI/2) lc.push_back(i);
                else rc.push_back(i);
            end
        end
        mu = (lc.size() > 1) || (rc.size() > 1);
        mg = 1'b0;
        if (lc.size() == 1 && rc.size() == 1)
            mg = (ln[lc[0]][RLO +: 4] == ln[rc[0]][RLO +: 4]);
        res = b;
        if (!mg) return;
        L = lc[0];
        R = rc[0];
        for (int s = 0; s < NS; s++) begin
            a = longint'($signed(ln[L][s*32 +: 32])) + longint'($signed(ln[R][s*32 +: 32]));
`ifdef FAN_ADD_SAT_EN
            if (a > 64'sd2147483647) a = 64'sd2147483647;
            if (a < -64'sd2147483648) a = -64'sd2147483648;
`endif
            sum[s*32 +: 32] = a[31:0];
        end
        row = ln[L][RLO +: 4];
        lb = ln[L][LW-4 +: 2];
        rb = ln[R][LW-4 +: 2];
        if (lb == 2'b01 && rb == 2'b10) begin cc = 4'b0111; pos = NI/2 - 1; end
        else if (lb == 2'b01)           begin cc = 4'b1001; pos = NI/2; end
        else if (rb == 2'b10)           begin cc = 4'b1010; pos = NI/2 - 1; end
        else                            begin cc = 4'b1000; pos = (SYM == 1) ? NI/2 : NI/2 - 1; end
        for (int i = 0; i < NI; i++)
            if (i == L || i == R || !ln[i][LW-2]) ln[i] = '0;
        ln[NI/2-1] = '0;
        ln[NI/2]   = '0;
        ln[pos]    = {cc, row, sum};
        for (int i = 0; i < NI; i++) res[i*LW +: LW] = ln[i];
    endfunction

    function automatic logic [BW-1:0] rnd_bundle();
        logic [BW-1:0] b;
        logic [3:0]    c, rl;
        int            l, r;
        for (int i = 0; i < NI; i++) begin
            case ($urandom_range(0, 5))
                0: c = 4'b0000;
                1: c = 4'b1000;
                2: c = 4'b1001;
                3: c = 4'b1010;
                4: c = 4'b1100;
                default: c = 4'($urandom());
            endcase
            b[i*LW +: LW] = {c, 4'($urandom_range(0, 1)), $urandom(), $urandom(), $urandom(), $urandom()};
        end
        if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < NI; i++)
                b[LW*i + LW-4 +: 2] = 2'b01 << $urandom_range(0, 1);
            for (int i = 0; i < NI; i++)
                b[LW*i + LW-2 +: 2] = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00;
            l  = $urandom_range(0, NI/2 - 1);
            r  = $urandom_range(NI/2, NI - 1);
            rl = 4'($urandom_range(0, 3));
            b[l*LW + LW-4 +: 4] = {2'b10, 2'($urandom())};
            b[r*LW + LW-4 +: 4] = {2'b10, 2'($urandom())};
            b[l*LW + RLO +: 4]  = rl;
            b[r*LW + RLO +: 4]  = ($urandom_range(0, 3) != 0) ? rl : rl + 4'd1;
        end
        return b;
    endfunction

    task automatic tick();
        bit            drn[2];
        logic [BW-1:0] m;
        bit            mg, mu, ev;
        #1;
        for (int k = 0; k < 2; k++) begin
            acc_last[k] = iv[k] && ir[k];
            blocked[k]  = iv[k] && !ir[k];
            drn[k]      = ov[k] && ordy[k];
            chk($sformatf("d%0d_in_ready", k), ir[k], (tl[k] - hd[k] < k + 1) || ordy[k]);
        end
        @(posedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (drn[k]) begin
                hd[k]++;
                delivered[k]++;
            end
            if (acc_last[k]) begin
                model(din[k], m, mg, mu);
                sb_b[k][tl[k]] = m;
                sb_t[k][tl[k]] = cyc;
                tl[k]++;
                if (mg && exp_cnt[k] != 65535) exp_cnt[k]++;
                if (mu) exp_err[k] = 1'b1;
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            ev = (tl[k] > hd[k]) && (cyc - sb_t[k][hd[k]] >= k);
            chk($sformatf("d%0d_out_valid", k), ov[k], ev);
            if (ev) chk($sformatf("d%0d_out", k), dout[k], sb_b[k][hd[k]]);
            chk($sformatf("d%0d_merge_cnt", k), mcnt[k], exp_cnt[k]);
            chk($sformatf("d%0d_err_multi", k), emul[k], exp_err[k]);
        end
    endtask

    task automatic send(input logic [BW-1:0] b);
        din[0] = b;
        din[1] = b;
        iv[0]  = 1'b1;
        iv[1]  = 1'b1;
        tick();
        iv[0]  = 1'b0;
        iv[1]  = 1'b0;
    endtask

    initial begin
        logic [BW-1:0] b, bs[5];
        int            idx, d0;
        bit            saw_block;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b1; din[k] = '0;
            hd[k] = 0; tl[k] = 0; exp_cnt[k] = 0; exp_err[k] = 1'b0;
            delivered[k] = 0; acc_last[k] = 1'b0; blocked[k] = 1'b0;
        end

        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_out_valid", ov[k], 1'b0);
            chk("reset_out", dout[k], '0);
            chk("reset_merge_cnt", mcnt[k], '0);
            chk("reset_err_multi", emul[k], 1'b0);
        end
        #3 rst_n = 1'b1;
        tick();

        // basic merge: start + end boundaries collapse to 0111 at OUT_LEFT
        b = '0;
        b[2*LW +: LW] = mk(4'b1001, 4'd3, 32'd5);
        b[3*LW +: LW] = mk(4'b1010, 4'd3, 32'd7);
        send(b);
        chk("t1_lane2", dout[0][2*LW +: LW], mk(4'b0111, 4'd3, 32'd12));
        chk("t1_lane3", dout[0][3*LW +: LW], '0);
        chk("t1_cnt", mcnt[0], 16'd1);
        tick();
        tick();

        b[3*LW +: LW] = mk(4'b1010, 4'd4, 32'd7);
        send(b);
        chk("t2_bypass", dout[0], b);
        chk("t2_cnt", mcnt[0], 16'd1);
        tick();
        tick();

        b = '0;
        b[2*LW +: LW] = mk(4'b1000, 4'd1, 32'h7FFFFFF0);
        b[3*LW +: LW] = mk(4'b1000, 4'd1, 32'h00000020);
        send(b);
        chk("t5_sat_word", dout[0][2*LW +: 32], SAT_EXP);
        chk("t5_sat_lane", dout[0][2*LW +: LW], mk(4'b1000, 4'd1, SAT_EXP));
        tick();
        tick();

        b = '0;
        b[0*LW +: LW] = mk(4'b1000, 4'd3, 32'd9);
        b[2*LW +: LW] = mk(4'b1001, 4'd3, 32'd5);
        b[3*LW +: LW] = mk(4'b1010, 4'd3, 32'd7);
        send(b);
        chk("t3_bypass", dout[0], b);
        chk("t3_err", emul[0], 1'b1);
        tick();
        tick();
        chk("t3_err_sticky", emul[1], 1'b1);

        // two-stage instance: five bundles with a three-cycle downstream stall
        for (int i = 0; i < 5; i++) bs[i] = rnd_bundle();
        idx = 0;
        d0 = delivered[1];
        saw_block = 1'b0;
        for (int t = 0; t < 40 && delivered[1] - d0 < 5; t++) begin
            ordy[1] = !(t >= 3 && t <= 5);
            iv[1]   = (idx < 5);
            if (idx < 5) din[1] = bs[idx];
            tick();
            if (blocked[1]) saw_block = 1'b1;
            if (acc_last[1]) idx++;
        end
        iv[1] = 1'b0;
        ordy[1] = 1'b1;
        chk("t4_delivered", delivered[1] - d0, 5);
        chk("t4_in_ready_low", saw_block, 1'b1);

        // asynchronous reset while both outputs are stalled
        ordy[0] = 1'b0;
        ordy[1] = 1'b0;
        b = '0;
        b[2*LW +: LW] = mk(4'b1001, 4'd3, 32'd5);
        b[3*LW +: LW] = mk(4'b1010, 4'd3, 32'd7);
        send(b);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t6_out_valid", ov[k], 1'b0);
            chk("t6_out", dout[k], '0);
            chk("t6_merge_cnt", mcnt[k], '0);
            chk("t6_err_multi", emul[k], 1'b0);
            hd[k] = 0; tl[k] = 0; exp_cnt[k] = 0; exp_err[k] = 1'b0;
            ordy[k] = 1'b1;
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (!iv[k] || acc_last[k]) begin
                    iv[k]  = ($urandom_range(0, 3) != 0);
                    din[k] = rnd_bundle();
                end
                ordy[k] = ($urandom_range(0, 3) != 0);
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0;
            ordy[k] = 1'b1;
        end
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
